pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 21 ++
 rtl/sync_ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 110 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      GAP  = 2'd1,
      RUN  = 2'd2
   } seq_state_t;

   localparam int unsigned LOSS_W = 8;

   // Width able to hold the larger of the two terminal counts (minimum 1 bit).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      int unsigned w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for asynchronous inputs; output is the last stage.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Waits for a stable PLL lock, then releases rst_early and, after a fixed gap, rst_late.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned GAP_CYCLES    = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              locked,
   output logic              rst_early,
   output logic              rst_late,
   output logic              ready,
   output logic              lock_s,
   output logic [LOSS_W-1:0] loss_count
);

   localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              early_d, late_d, ready_d;
   logic [LOSS_W-1:0] loss_d;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (locked),
      .q       (lock_s)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= WAIT;
         cnt_q      <= '0;
         rst_early  <= 1'b1;
         rst_late   <= 1'b1;
         ready      <= 1'b0;
         loss_count <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_early  <= early_d;
         rst_late   <= late_d;
         ready      <= ready_d;
         loss_count <= loss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      early_d = rst_early;
      late_d  = rst_late;
      ready_d = ready;
      loss_d  = loss_count;

      // Lock loss outside WAIT wins over any terminal count on the same edge.
      if (!lock_s && state_q != WAIT) begin
         state_d = WAIT;
         cnt_d   = '0;
         early_d = 1'b1;
         late_d  = 1'b1;
         ready_d = 1'b0;
         if (state_q == RUN && loss_count != '1) begin
            loss_d = loss_count + LOSS_W'(1);
         end
      end else begin
         case (state_q)
            WAIT: begin
               if (!lock_s) begin
                  cnt_d = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  cnt_d   = '0;
                  early_d = 1'b0;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  late_d  = 1'b0;
                  ready_d = 1'b1;
                  state_d = RUN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               state_d = RUN;
            end
            default: begin
               state_d = WAIT;
               cnt_d   = '0;
               early_d = 1'b1;
               late_d  = 1'b1;
               ready_d = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised and directed bench for pll_reset_sequencer against a lock-run-length model.
module tb_pll_reset_sequencer;

   localparam int SYNC = 2;
   localparam int S    = 16;
   localparam int G    = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       locked = 1'b0;
   logic       rst_early, rst_late, ready, lock_s;
   logic [7:0] loss_count;

   int n_checks = 0;
   int n_err    = 0;

   // Model: lock history, consecutive-lock run length as seen by the sequencer, loss tally.
   bit msync [SYNC];
   int run  = 0;
   int loss = 0;
   int edge_n = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (S),
      .GAP_CYCLES    (G)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .locked     (locked),
      .rst_early  (rst_early),
      .rst_late   (rst_late),
      .ready      (ready),
      .lock_s     (lock_s),
      .loss_count (loss_count)
   );

   always #5 clock = ~clock;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic lk, input logic rn);
      bit seen;
      locked  = lk;
      reset_n = rn;
      @(posedge clock);
      if (!rn) begin
         for (int i = 0; i < SYNC; i++) msync[i] = 1'b0;
         run    = 0;
         loss   = 0;
         edge_n = 0;
      end else begin
         seen = msync[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) msync[i] = msync[i-1];
         msync[0] = lk;
         if (seen) begin
            if (run < 1000000) run++;
         end else begin
            if (run >= S + G && loss < 255) loss++;
            run = 0;
         end
         edge_n++;
      end
      #1;
      check("rst_early", rst_early, run < S);
      check("rst_late", rst_late, run < S + G);
      check("ready", ready, run >= S + G);
      check("lock_s", lock_s, msync[SYNC-1]);
      check("loss_count", loss_count, loss);
      check("order", (rst_early == 1'b1 && rst_late == 1'b0), 0);
   endtask

   task automatic measure(input int drop_edge, input int n, output int fe, output int fl);
      fe = -1;
      fl = -1;
      for (int e = 1; e <= n; e++) begin
         step((e == drop_edge) ? 1'b0 : 1'b1, 1'b1);
         if (rst_early == 1'b0 && fe < 0) fe = edge_n;
         if (rst_late == 1'b0 && fl < 0) fl = edge_n;
      end
   endtask

   initial begin
      int fe, fl, hold;
      logic lv;

      // Power-up.
      repeat (3) step(1'b1, 1'b0);
      check("rst_val_early", rst_early, 1);
      check("rst_val_loss", loss_count, 0);
      measure(-1, 30, fe, fl);
      check("pwr_early_edge", fe, SYNC + S);
      check("pwr_late_edge", fl, SYNC + S + G);
      check("pwr_loss", loss_count, 0);

      // One-cycle glitch while waiting for stability.
      step(1'b1, 1'b0);
      measure(10, 40, fe, fl);
      check("glitch_early_edge", fe, 10 + SYNC + S);
      check("glitch_late_edge", fl, 10 + SYNC + S + G);

      // Lock loss during the gap.
      step(1'b1, 1'b0);
      for (int e = 1; e <= 26; e++) begin
         step((e < 18) ? 1'b1 : 1'b0, 1'b1);
         if (edge_n == 19) check("gap_early_low", rst_early, 0);
         if (edge_n == 20) begin
            check("gap_loss_early", rst_early, 1);
            check("gap_loss_late", rst_late, 1);
            check("gap_loss_ready", ready, 0);
            check("gap_loss_count", loss_count, 0);
         end
      end

      // Repeated loss in RUN, saturating the counter.
      step(1'b1, 1'b0);
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < 60 && ready !== 1'b1; k++) step(1'b1, 1'b1);
         check("relock_ready", ready, 1);
         repeat (SYNC + 1) step(1'b0, 1'b1);
         check("run_loss_early", rst_early, 1);
         check("run_loss_late", rst_late, 1);
         check("run_loss_count", loss_count, (i + 1 > 255) ? 255 : i + 1);
      end

      // Reset pulse while in RUN, then identical re-run timing.
      for (int k = 0; k < 60 && ready !== 1'b1; k++) step(1'b1, 1'b1);
      check("pre_reset_ready", ready, 1);
      step(1'b1, 1'b0);
      check("rrun_early", rst_early, 1);
      check("rrun_late", rst_late, 1);
      check("rrun_ready", ready, 0);
      check("rrun_lock_s", lock_s, 0);
      check("rrun_loss", loss_count, 0);
      measure(-1, 30, fe, fl);
      check("rerun_early_edge", fe, SYNC + S);
      check("rerun_late_edge", fl, SYNC + S + G);

      // Random lock toggling with occasional resets.
      lv = 1'b1;
      hold = 0;
      for (int c = 0; c < 10000; c++) begin
         if (hold == 0) begin
            lv   = ~lv;
            hold = (lv) ? $urandom_range(1, 3 * (SYNC + S + G)) : $urandom_range(1, 6);
         end
         hold--;
         step(lv, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
